// File: rtl/rsp_s1_prep_dc_remove.sv
// rtl/rsp_s1_prep_dc_remove.sv - per-chirp DC mean estimate and subtraction ahead of the prep multiplier
// Samples are packed {imag, real}; each sample is offset by the previous chirp's mean.
module rsp_s1_prep_dc_remove #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int LOG2_LEN     = 8,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH/2 + LOG2_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_bypass,
  input  logic [SAMPLE_WIDTH-1:0] i_x0_data,
  input  logic                    i_x0_valid,
  input  logic                    i_sop,
  output logic [SAMPLE_WIDTH-1:0] o_y0,
  output logic                    o_y0_valid,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic [SAMPLE_WIDTH-1:0] o_mean,
  output logic                    o_mean_valid,
  output logic                    o_err
);

  localparam int CW = SAMPLE_WIDTH / 2;
  localparam logic [LOG2_LEN-1:0] CNT_ONE  = LOG2_LEN'(1);
  localparam logic [LOG2_LEN-1:0] CNT_LAST = {LOG2_LEN{1'b1}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state_q;
  logic [LOG2_LEN-1:0]        cnt_q;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_im_q;
  logic [CW-1:0]              u_re_q, u_im_q;
  logic                       mean_valid_q, err_q;

  logic [CW-1:0]              s1_x_re_q, s1_x_im_q, s1_u_re_q, s1_u_im_q;
  logic                       s1_valid_q, s1_sop_q, s1_eop_q, s1_byp_q;

  logic [SAMPLE_WIDTH-1:0]    y_q;
  logic                       y_valid_q, sop_q, eop_q;

  logic signed [ACC_WIDTH-1:0] x_re_ext, x_im_ext;
  logic signed [ACC_WIDTH-1:0] acc_re_d, acc_im_d;
  logic signed [ACC_WIDTH-1:0] mean_re_full, mean_im_full;
  logic [CW-1:0]              u_re_d, u_im_d;
  logic                       complete;

  always_comb begin
    x_re_ext     = {{LOG2_LEN{i_x0_data[CW-1]}}, i_x0_data[CW-1:0]};
    x_im_ext     = {{LOG2_LEN{i_x0_data[SAMPLE_WIDTH-1]}}, i_x0_data[SAMPLE_WIDTH-1:CW]};
    acc_re_d     = acc_re_q + x_re_ext;
    acc_im_d     = acc_im_q + x_im_ext;
    // Arithmetic shift floors toward -inf, so a sum of -1 gives a mean of -1.
    mean_re_full = acc_re_d >>> LOG2_LEN;
    mean_im_full = acc_im_d >>> LOG2_LEN;
    u_re_d       = mean_re_full[CW-1:0];
    u_im_d       = mean_im_full[CW-1:0];
    complete     = (state_q == ACCUM) && i_x0_valid && !i_sop && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      u_re_q       <= '0;
      u_im_q       <= '0;
      mean_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mean_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (i_x0_valid) begin
        if (i_sop) begin
          // A sop while accumulating abandons the partial chirp and restarts on this sample.
          err_q    <= (state_q == ACCUM);
          acc_re_q <= x_re_ext;
          acc_im_q <= x_im_ext;
          cnt_q    <= CNT_ONE;
          state_q  <= ACCUM;
        end else if (state_q == ACCUM) begin
          if (cnt_q == CNT_LAST) begin
            u_re_q       <= u_re_d;
            u_im_q       <= u_im_d;
            mean_valid_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            cnt_q    <= cnt_q + CNT_ONE;
          end
        end
      end
    end
  end

  // Stage 1: the mean is captured with the sample, before this edge's mean update lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_x_re_q  <= '0;
      s1_x_im_q  <= '0;
      s1_u_re_q  <= '0;
      s1_u_im_q  <= '0;
    end else begin
      s1_valid_q <= i_x0_valid;
      if (i_x0_valid) begin
        s1_sop_q  <= i_sop;
        s1_eop_q  <= complete;
        s1_byp_q  <= i_bypass;
        s1_x_re_q <= i_x0_data[CW-1:0];
        s1_x_im_q <= i_x0_data[SAMPLE_WIDTH-1:CW];
        s1_u_re_q <= u_re_q;
        s1_u_im_q <= u_im_q;
      end
    end
  end

  function automatic logic [CW-1:0] sat(input logic [CW:0] d);
    logic [CW-1:0] r;
    if (d[CW] != d[CW-1]) r = d[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    else                  r = d[CW-1:0];
    return r;
  endfunction

  logic [CW:0]   diff_re, diff_im;
  logic [CW-1:0] sat_re, sat_im;

  always_comb begin
    diff_re = {s1_x_re_q[CW-1], s1_x_re_q} - {s1_u_re_q[CW-1], s1_u_re_q};
    diff_im = {s1_x_im_q[CW-1], s1_x_im_q} - {s1_u_im_q[CW-1], s1_u_im_q};
    sat_re  = sat(diff_re);
    sat_im  = sat(diff_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      y_valid_q <= s1_valid_q;
      sop_q     <= s1_valid_q & s1_sop_q;
      eop_q     <= s1_valid_q & s1_eop_q;
      if (s1_valid_q) begin
        y_q <= s1_byp_q ? {s1_x_im_q, s1_x_re_q} : {sat_im, sat_re};
      end
    end
  end

  assign o_y0         = y_q;
  assign o_y0_valid   = y_valid_q;
  assign o_sop        = sop_q;
  assign o_eop        = eop_q;
  assign o_mean       = {u_im_q, u_re_q};
  assign o_mean_valid = mean_valid_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_rsp_s1_prep_dc_remove.sv
// tb/tb_rsp_s1_prep_dc_remove.sv - directed self-checking bench for rsp_s1_prep_dc_remove
module tb_rsp_s1_prep_dc_remove;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_bypass;
  logic [31:0] i_x0_data;
  logic        i_x0_valid;
  logic        i_sop;
  logic [31:0] o_y0;
  logic        o_y0_valid;
  logic        o_sop;
  logic        o_eop;
  logic [31:0] o_mean;
  logic        o_mean_valid;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic        sop;
    logic        eop;
    logic        mv;
    logic        err;
    logic [31:0] y;
  } exp_t;

  exp_t cur, pa, pb;

  rsp_s1_prep_dc_remove #(.SAMPLE_WIDTH(32), .LOG2_LEN(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_bypass     (i_bypass),
    .i_x0_data    (i_x0_data),
    .i_x0_valid   (i_x0_valid),
    .i_sop        (i_sop),
    .o_y0         (o_y0),
    .o_y0_valid   (o_y0_valid),
    .o_sop        (o_sop),
    .o_eop        (o_eop),
    .o_mean       (o_mean),
    .o_mean_valid (o_mean_valid),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int im, input int re);
    return {16'(im), 16'(re)};
  endfunction

  // Output of the sample seen at negedge k shows at negedge k+2; mean/err pulses at k+1.
  always @(negedge clk) begin
    if (rst) begin
      pa = '0;
      pb = '0;
    end else begin
      chk("y_valid", {31'd0, o_y0_valid}, {31'd0, pa.v});
      chk("sop", {31'd0, o_sop}, {31'd0, pa.sop});
      chk("eop", {31'd0, o_eop}, {31'd0, pa.eop});
      if (pa.v) chk("y", o_y0, pa.y);
      chk("mean_valid", {31'd0, o_mean_valid}, {31'd0, pb.mv});
      chk("err", {31'd0, o_err}, {31'd0, pb.err});
      pa = pb;
      pb = cur;
    end
  end

  task automatic drive(input logic v, input logic sop, input logic byp,
                       input int im, input int re, input int e_im, input int e_re,
                       input logic eop, input logic mv, input logic err);
    @(posedge clk);
    #1;
    i_x0_valid = v;
    i_sop      = sop;
    i_bypass   = byp;
    i_x0_data  = pk(im, re);
    cur.v      = v;
    cur.sop    = v & sop;
    cur.eop    = eop;
    cur.mv     = mv;
    cur.err    = err;
    cur.y      = pk(e_im, e_re);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chirp(input int n, input int im, input int re, input int e_im, input int e_re,
                       input logic byp, input logic sop0, input logic last, input logic err0,
                       input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0 && (i % gap) == 0) idle(1);
      drive(1'b1, sop0 && i == 0, byp, im, re, e_im, e_re,
            last && i == n-1, last && i == n-1, err0 && i == 0);
    end
  endtask

  initial begin
    cur        = '0;
    rst        = 1'b1;
    i_bypass   = 1'b0;
    i_x0_data  = '0;
    i_x0_valid = 1'b0;
    i_sop      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", o_y0, 32'd0);
    chk("rst_valid", {31'd0, o_y0_valid}, 32'd0);
    chk("rst_mean", o_mean, 32'd0);
    chk("rst_flags", {27'd0, o_sop, o_eop, o_mean_valid, o_err, 1'b0}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back chirps of {-50,100}
    chirp(256, -50, 100, -50, 100, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chirp(256, -50, 100, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(3);
    chk("mean_b2b", o_mean, pk(-50, 100));

    // floor rounding: sum of -1 gives mean -1
    chirp(255, 0, 0, 50, -100, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, -1, 50, -101, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("mean_floor", o_mean, pk(0, -1));
    chirp(256, 0, 0, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(2);
    chk("mean_zero", o_mean, pk(0, 0));

    // saturation both directions
    chirp(256, 0, -32768, 0, -32768, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(2);
    chk("mean_neg", o_mean, pk(0, -32768));
    chirp(256, 0, 32767, 0, 32767, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(2);
    chk("mean_pos", o_mean, pk(0, 32767));
    chirp(256, 0, -32768, 0, -32768, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // sop at sample 100 restarts the chirp
    chirp(100, 0, -32768, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chirp(1, 20, 10, 20, 32767, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(2);
    chk("mean_after_err", o_mean, pk(0, -32768));
    chirp(255, 20, 10, 20, 32767, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(2);
    chk("mean_restart", o_mean, pk(20, 10));

    // bypass keeps the mean path running
    chirp(256, 0, 7, 0, 7, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    idle(2);
    chk("mean_bypass", o_mean, pk(0, 7));
    chirp(256, 0, 7, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // asynchronous reset mid-chirp with gaps
    chirp(50, 0, 7, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 10);
    #2;
    rst        = 1'b1;
    i_x0_valid = 1'b0;
    i_sop      = 1'b0;
    cur        = '0;
    #1;
    chk("arst_y", o_y0, 32'd0);
    chk("arst_valid", {31'd0, o_y0_valid}, 32'd0);
    chk("arst_mean", o_mean, 32'd0);
    chk("arst_flags", {28'd0, o_sop, o_eop, o_mean_valid, o_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chirp(256, -4, 3, -4, 3, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(3);
    chk("mean_post_rst", o_mean, pk(-4, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
